// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch display path: active-low segment codes
// ({dp,g,f,e,d,c,b,a}), display slot indices and the adjust-field encoding.
package stopwatch_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DP_ON = 8'h7F;

  typedef logic [1:0] slot_t;

  localparam slot_t SLOT_SEC_BOT = 2'd0;
  localparam slot_t SLOT_SEC_TOP = 2'd1;
  localparam slot_t SLOT_MIN_BOT = 2'd2;
  localparam slot_t SLOT_MIN_TOP = 2'd3;

  typedef enum logic {
    FIELD_MIN = 1'b0,
    FIELD_SEC = 1'b1
  } field_e;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decode; the decimal point is left off.
// Codes 10-15 show a dash so an illegal counter state is visible on the display.
module bcd_to_seg
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Four-digit MM.SS multiplexed display driver: scan prescaler, per-frame digit
// snapshot, adjust-mode blink of the selected field, registered an/seg outputs.
module seg7_scan_display
  import stopwatch_pkg::*;
#(
  parameter int SCAN_DIV  = 100_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] minutes_top_digit,
  input  logic [3:0] minutes_bot_digit,
  input  logic [3:0] seconds_top_digit,
  input  logic [3:0] seconds_bot_digit,
  input  logic       adj,
  input  logic       sel,
  output logic [7:0] seg,
  output logic [3:0] an
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [SCAN_W-1:0]  scan_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_on;
  slot_t              idx;
  logic [3:0][3:0]    snap;

  logic               scan_tc;
  logic               frame_wrap;
  logic [7:0]         dec_seg;
  logic               blank;
  field_e             cur_field;
  field_e             sel_field;
  logic [3:0]         an_next;
  logic [7:0]         seg_next;

  assign scan_tc    = (scan_cnt == SCAN_LAST);
  assign frame_wrap = scan_tc && (idx == SLOT_MIN_TOP);

  bcd_to_seg u_bcd_to_seg (
    .bcd (snap[idx]),
    .seg (dec_seg)
  );

  // adj/sel are used live so a field change shows on the very next edge.
  always_comb begin
    cur_field = idx[1] ? FIELD_MIN : FIELD_SEC;
    sel_field = sel ? FIELD_SEC : FIELD_MIN;
    blank     = adj && !blink_on && (cur_field == sel_field);
    an_next   = ~(4'b0001 << idx);
    seg_next  = (idx == SLOT_MIN_BOT) ? (dec_seg & SEG_DP_ON) : dec_seg;
    if (blank) begin
      an_next  = 4'b1111;
      seg_next = SEG_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= SLOT_SEC_BOT;
    end else if (scan_tc) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Capture on the 3->0 wrap so a frame never mixes old and new digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap <= '0;
    end else if (frame_wrap) begin
      snap[SLOT_MIN_TOP] <= minutes_top_digit;
      snap[SLOT_MIN_BOT] <= minutes_bot_digit;
      snap[SLOT_SEC_TOP] <= seconds_top_digit;
      snap[SLOT_SEC_BOT] <= seconds_bot_digit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !adj) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_on  <= !blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with SCAN_DIV=4, BLINK_DIV=8; expected
// slot sequence, digit codes and blink phases are written out by hand below.
module tb_seg7_scan_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] minutes_top_digit;
  logic [3:0] minutes_bot_digit;
  logic [3:0] seconds_top_digit;
  logic [3:0] seconds_bot_digit;
  logic       adj;
  logic       sel;
  logic [7:0] seg;
  logic [3:0] an;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;
  int blink_base = 0;

  always #5 clk = ~clk;

  seg7_scan_display #(
    .SCAN_DIV  (4),
    .BLINK_DIV (8)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .minutes_top_digit (minutes_top_digit),
    .minutes_bot_digit (minutes_bot_digit),
    .seconds_top_digit (seconds_top_digit),
    .seconds_bot_digit (seconds_bot_digit),
    .adj               (adj),
    .sel               (sel),
    .seg               (seg),
    .an                (an)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edge n (counted from reset release) drives slot (n/4)%4; while adj=1 the
  // selected field is dark during every second 8-edge phase, starting visible.
  task automatic scan_step(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                           input logic [7:0] s2, input logic [7:0] s3);
    int slot;
    logic dark;
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    slot = (edge_n / 4) % 4;
    dark = adj && ((((edge_n - blink_base) / 8) % 2) == 1) && (sel ? (slot < 2) : (slot >= 2));
    case (slot)
      0:       exp_seg = s0;
      1:       exp_seg = s1;
      2:       exp_seg = s2;
      default: exp_seg = s3;
    endcase
    exp_an = ~(4'b0001 << slot);
    if (dark) begin
      exp_an  = 4'b1111;
      exp_seg = 8'hFF;
    end
    tick();
    check($sformatf("%s_an_e%0d", tag, edge_n), {4'h0, an}, {4'h0, exp_an});
    check($sformatf("%s_seg_e%0d", tag, edge_n), seg, exp_seg);
    edge_n++;
  endtask

  task automatic run(input int n, input string tag, input logic [7:0] s0, input logic [7:0] s1,
                     input logic [7:0] s2, input logic [7:0] s3);
    for (int i = 0; i < n; i++) scan_step(tag, s0, s1, s2, s3);
  endtask

  initial begin
    rst = 1'b1;
    adj = 1'b0;
    sel = 1'b0;
    minutes_top_digit = 4'd0;
    minutes_bot_digit = 4'd0;
    seconds_top_digit = 4'd0;
    seconds_bot_digit = 4'd0;

    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_an_%0d", i), {4'h0, an}, 8'h0F);
      check($sformatf("rst_seg_%0d", i), seg, 8'hFF);
    end

    // Release; new inputs only show from the second frame.
    rst = 1'b0;
    minutes_top_digit = 4'd1;
    minutes_bot_digit = 4'd2;
    seconds_top_digit = 4'd3;
    seconds_bot_digit = 4'd4;
    edge_n = 0;
    run(16, "frame0", 8'hC0, 8'hC0, 8'h40, 8'hC0);
    run(16, "decode", 8'h99, 8'hB0, 8'h24, 8'hF9);

    // Mid-frame change while slot 1 is driven.
    run(5, "snap_pre", 8'h99, 8'hB0, 8'h24, 8'hF9);
    seconds_bot_digit = 4'd7;
    minutes_top_digit = 4'd5;
    run(11, "snap_hold", 8'h99, 8'hB0, 8'h24, 8'hF9);
    run(8, "snap_new", 8'hF8, 8'hB0, 8'h24, 8'h92);

    // Blink seconds field; dark phase lands on slots 0,1.
    adj = 1'b1;
    sel = 1'b1;
    blink_base = edge_n;
    run(10, "blink_sec", 8'hF8, 8'hB0, 8'h24, 8'h92);
    sel = 1'b0;
    run(6, "blink_sel_min", 8'hF8, 8'hB0, 8'h24, 8'h92);
    adj = 1'b0;
    run(8, "adj_off", 8'hF8, 8'hB0, 8'h24, 8'h92);
    adj = 1'b1;
    blink_base = edge_n;
    run(16, "blink_min", 8'hF8, 8'hB0, 8'h24, 8'h92);

    adj = 1'b0;
    seconds_bot_digit = 4'd12;
    minutes_top_digit = 4'd15;
    run(16, "illegal_hold", 8'hF8, 8'hB0, 8'h24, 8'h92);
    run(16, "illegal", 8'hBF, 8'hB0, 8'h24, 8'hBF);

    adj = 1'b1;
    sel = 1'b1;
    blink_base = edge_n;
    run(9, "pre_rst", 8'hBF, 8'hB0, 8'h24, 8'hBF);
    rst = 1'b1;
    tick();
    check("midrst_an", {4'h0, an}, 8'h0F);
    check("midrst_seg", seg, 8'hFF);
    rst = 1'b0;
    edge_n = 0;
    blink_base = 0;
    run(16, "post_rst", 8'hC0, 8'hC0, 8'h40, 8'hC0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
